// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the processor's control unit:
// state encoding, special instruction words and the instruction field layout.
package instruction_fetch_unit_pkg;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    localparam logic [8:0] DEPTH_CNT = 9'd256;

    localparam logic [7:0] HALT_OP  = 8'hC0;
    localparam logic [7:0] NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Field layout op[7:6], rs[5:4], rt[3:2], rd[1:0]; HALT_OP is a branch with offset 0.
    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] rd;
    } instr_t;

endpackage

// File: rtl/instruction_fetch_unit_program_memory.sv
// Program image store: one synchronous write port for the loader and one
// asynchronous read port so the processor sees its instruction in the same cycle.
module instruction_fetch_unit_program_memory
    import instruction_fetch_unit_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // Deliberately not reset; stale words beyond the image are never served.
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction-side responder: loads a program image over a byte stream, holds the
// processor in reset while loading, serves instructions by PC and detects halt.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic [7:0]  pc,
    output logic [7:0]  instruction,
    output logic        cpu_reset,
    output logic [8:0]  load_count,
    output logic        halted,
    output logic [15:0] run_cycles,
    output state_e      dbg_state
);

    // Load handshake: a byte transfers on a clk edge where load_valid && load_ready;
    // load_ready depends only on registered state, never on load_valid.

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [8:0]    load_count_q, load_count_d;
    logic          halted_q, halted_d;
    logic [15:0]   run_cycles_q, run_cycles_d;

    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          in_image;
    logic          enter_load;

    instruction_fetch_unit_program_memory u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (load_data),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    assign in_image = ({1'b0, pc} < load_count_q);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        halted_d     = halted_q;
        run_cycles_d = run_cycles_q;
        load_ready   = 1'b0;
        cpu_reset    = 1'b1;
        instruction  = NOP_WORD;
        mem_we       = 1'b0;
        enter_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                enter_load = load_en;
            end
            ST_LOAD: begin
                load_ready = (load_count_q < DEPTH_CNT);
                if (load_valid && load_ready) begin
                    mem_we       = 1'b1;
                    wr_ptr_d     = wr_ptr_q + 8'd1;
                    load_count_d = load_count_q + 9'd1;
                end
                // A byte accepted in the exit cycle still counts toward a runnable image.
                if (!load_en) begin
                    state_d = (load_count_d != 9'd0) ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                cpu_reset   = 1'b0;
                instruction = in_image ? mem_rdata : HALT_OP;
                if (run_cycles_q != 16'hFFFF) begin
                    run_cycles_d = run_cycles_q + 16'd1;
                end
                if (load_en) begin
                    enter_load = 1'b1;
                end else if (instruction == HALT_OP) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_HALT: begin
                cpu_reset   = 1'b0;
                instruction = HALT_OP;
                enter_load  = load_en;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_load) begin
            state_d      = ST_LOAD;
            wr_ptr_d     = '0;
            load_count_d = '0;
            run_cycles_d = '0;
            halted_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            halted_q     <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
            halted_q     <= halted_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign load_count = load_count_q;
    assign halted     = halted_q;
    assign run_cycles = run_cycles_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: load, run, halt, backpressure,
// overflow, out-of-image fetch, reload and asynchronous reset.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        load_en;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic [7:0]  pc;
    logic [7:0]  instruction;
    logic        cpu_reset;
    logic [8:0]  load_count;
    logic        halted;
    logic [15:0] run_cycles;
    state_e      dbg_state;

    int checks;
    int failures;

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .pc          (pc),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_count  (load_count),
        .halted      (halted),
        .run_cycles  (run_cycles),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        load_en    = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        pc         = 8'h00;
        #3;
        checks++;
        if (dbg_state !== ST_IDLE || cpu_reset !== 1'b1 || load_ready !== 1'b0 ||
            instruction !== 8'h00 || load_count !== 9'd0 || halted !== 1'b0 ||
            run_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_values: state=%0d cpu_reset=%b ready=%b instr=%h count=%0d halted=%b cycles=%0d required 0 1 0 00 0 0 0",
                     dbg_state, cpu_reset, load_ready, instruction, load_count, halted, run_cycles);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_run();
        logic [7:0] img [4];
        img = '{8'h15, 8'h26, 8'h37, 8'hC0};
        load_en = 1'b1;
        tick();
        checks++;
        if (dbg_state !== ST_LOAD || load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL load_entry: state=%0d ready=%b cpu_reset=%b required 1 1 1", dbg_state, load_ready, cpu_reset);
        end
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = img[i];
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (load_count !== 9'd4) begin
            failures++;
            $display("FAIL basic_count: got %0d required 4", load_count);
        end
        load_en = 1'b0;
        tick();
        checks++;
        if (dbg_state !== ST_RUN || cpu_reset !== 1'b0 || run_cycles !== 16'd0) begin
            failures++;
            $display("FAIL run_entry: state=%0d cpu_reset=%b cycles=%0d required 2 0 0", dbg_state, cpu_reset, run_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i);
            #1;
            checks++;
            if (instruction !== img[i]) begin
                failures++;
                $display("FAIL basic_fetch pc=%0d: got %h required %h", i, instruction, img[i]);
            end
            tick();
        end
        pc = 8'd3;
        #1;
        checks++;
        if (instruction !== 8'hC0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL basic_halt_fetch: instr=%h halted=%b required c0 0", instruction, halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || dbg_state !== ST_HALT || run_cycles !== 16'd4) begin
            failures++;
            $display("FAIL basic_halted: halted=%b state=%0d cycles=%0d required 1 3 4", halted, dbg_state, run_cycles);
        end
        pc = 8'd0;
        tick();
        tick();
        tick();
        checks++;
        if (run_cycles !== 16'd4 || instruction !== 8'hC0 || cpu_reset !== 1'b0) begin
            failures++;
            $display("FAIL halt_frozen: cycles=%0d instr=%h cpu_reset=%b required 4 c0 0", run_cycles, instruction, cpu_reset);
        end
    endtask

    task automatic test_reload_from_halt();
        load_en = 1'b1;
        tick();
        checks++;
        if (cpu_reset !== 1'b1 || load_count !== 9'd0 || halted !== 1'b0 ||
            run_cycles !== 16'd0 || instruction !== 8'h00 || dbg_state !== ST_LOAD) begin
            failures++;
            $display("FAIL reload_entry: cpu_reset=%b count=%0d halted=%b cycles=%0d instr=%h state=%0d required 1 0 0 0 00 1",
                     cpu_reset, load_count, halted, run_cycles, instruction, dbg_state);
        end
        load_valid = 1'b1;
        load_data  = 8'h9A;
        tick();
        load_data = 8'hC0;
        load_en   = 1'b0;
        tick();
        load_valid = 1'b0;
        checks++;
        if (dbg_state !== ST_RUN || load_count !== 9'd2) begin
            failures++;
            $display("FAIL reload_exit_with_byte: state=%0d count=%0d required 2 2", dbg_state, load_count);
        end
        pc = 8'd0;
        #1;
        checks++;
        if (instruction !== 8'h9A) begin
            failures++;
            $display("FAIL reload_fetch0: got %h required 9a", instruction);
        end
        pc = 8'd1;
        #1;
        checks++;
        if (instruction !== 8'hC0) begin
            failures++;
            $display("FAIL reload_fetch1: got %h required c0", instruction);
        end
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || cpu_reset !== 1'b1 || load_count !== 9'd0 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL empty_load_idle: state=%0d cpu_reset=%b count=%0d ready=%b required 0 1 0 0",
                     dbg_state, cpu_reset, load_count, load_ready);
        end
    endtask

    task automatic test_backpressure();
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = 8'h40 + 8'(i / 2);
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (load_count !== 9'd10) begin
            failures++;
            $display("FAIL bp_count: got %0d required 10", load_count);
        end
        load_en = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            pc = 8'(i);
            #1;
            checks++;
            if (instruction !== 8'h40 + 8'(i)) begin
                failures++;
                $display("FAIL bp_readback pc=%0d: got %h required %h", i, instruction, 8'h40 + 8'(i));
            end
        end
        pc = 8'd10;
        #1;
        checks++;
        if (instruction !== 8'hC0) begin
            failures++;
            $display("FAIL bp_past_image: got %h required c0", instruction);
        end
    endtask

    task automatic test_overflow();
        logic ready_ok;
        ready_ok = 1'b1;
        load_en  = 1'b1;
        tick();
        for (int i = 0; i < 260; i++) begin
            if ((i < 256) !== load_ready) ready_ok = 1'b0;
            load_valid = 1'b1;
            load_data  = 8'(i) ^ 8'h5A;
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (!ready_ok) begin
            failures++;
            $display("FAIL ovf_ready_profile: load_ready not high exactly while count<256");
        end
        checks++;
        if (load_count !== 9'd256 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full: count=%0d ready=%b required 256 0", load_count, load_ready);
        end
        load_en = 1'b0;
        tick();
        pc = 8'd0;
        #1;
        checks++;
        if (instruction !== 8'h5A) begin
            failures++;
            $display("FAIL ovf_mem0: got %h required 5a", instruction);
        end
        pc = 8'd255;
        #1;
        checks++;
        if (instruction !== 8'hA5) begin
            failures++;
            $display("FAIL ovf_mem255: got %h required a5", instruction);
        end
    endtask

    task automatic test_out_of_image();
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i + 1);
            tick();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        tick();
        pc = 8'd5;
        #1;
        checks++;
        if (instruction !== 8'hC0 || halted !== 1'b0 || dbg_state !== ST_RUN) begin
            failures++;
            $display("FAIL ooi_fetch: instr=%h halted=%b state=%0d required c0 0 2", instruction, halted, dbg_state);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || dbg_state !== ST_HALT) begin
            failures++;
            $display("FAIL ooi_halted: halted=%b state=%0d required 1 3", halted, dbg_state);
        end
    endtask

    task automatic test_reset_midload();
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h70 + 8'(i);
            tick();
        end
        load_valid = 1'b0;
        load_en    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dbg_state !== ST_IDLE || cpu_reset !== 1'b1 || load_ready !== 1'b0 ||
            instruction !== 8'h00 || load_count !== 9'd0 || halted !== 1'b0 || run_cycles !== 16'd0) begin
            failures++;
            $display("FAIL midload_reset: state=%0d cpu_reset=%b ready=%b instr=%h count=%0d halted=%b cycles=%0d required 0 1 0 00 0 0 0",
                     dbg_state, cpu_reset, load_ready, instruction, load_count, halted, run_cycles);
        end
        #1;
        reset = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || load_count !== 9'd0 || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: state=%0d count=%0d cpu_reset=%b required 0 0 1", dbg_state, load_count, cpu_reset);
        end
        load_en = 1'b1;
        tick();
        checks++;
        if (dbg_state !== ST_LOAD || load_count !== 9'd0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_load: state=%0d count=%0d ready=%b required 1 0 1", dbg_state, load_count, load_ready);
        end
        load_en = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_run();
        test_reload_from_halt();
        test_backpressure();
        test_overflow();
        test_out_of_image();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
